// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, the scoreboard slot record
// and the forwarding-select encoding used by the hazard unit.
package mips_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    // Forwarding select 0 means "take the operand from the register file".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } slot_t;

endpackage

// File: rtl/hazard_match.sv
// Per-operand RAW check against the in-flight destination tags; returns the
// hazard flag and the forwarding select for one source register.
module hazard_match
    import mips_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int FWD_MODE   = 1,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  slot_t [DEPTH-1:0] slots_i,
    input  logic [REG_AW-1:0] src_i,
    input  logic              used_i,
    input  logic              id_valid_i,
    output logic              hazard_o,
    output logic [FW-1:0]     fwd_o
);

    logic consider;
    logic hit;
    logic hit_load;
    int   hit_k;

    assign consider = used_i && (src_i != '0) && id_valid_i;

    // Scan oldest to youngest so the youngest writer wins.
    always_comb begin
        hit      = 1'b0;
        hit_load = 1'b0;
        hit_k    = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slots_i[k].valid && (slots_i[k].rd == src_i)) begin
                hit      = 1'b1;
                hit_load = slots_i[k].is_load;
                hit_k    = k;
            end
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        fwd_o    = FW'(FWD_RF);
        if (consider && hit) begin
            if (FWD_MODE == 0) begin
                hazard_o = 1'b1;
            end else if (hit_load && (hit_k < LOAD_READY)) begin
                hazard_o = 1'b1;
            end else begin
                fwd_o = FW'(hit_k + 1);
            end
        end
    end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Decode-side scoreboard: shift-pipe of destination tags for EX/MEM/WB that
// drives the decode stall, operand forwarding selects and a stall counter.
module mips_hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int FWD_MODE   = 1,
    parameter int CW         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [AW-1:0]                id_rs,
    input  logic [AW-1:0]                id_rt,
    input  logic                         id_rs_used,
    input  logic                         id_rt_used,
    input  logic                         id_wr_en,
    input  logic [AW-1:0]                id_rd,
    input  logic                         id_is_load,
    input  logic                         flush,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_rs,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_rt,
    output logic [NREG-1:0]              busy,
    output logic [CW-1:0]                stall_count
);

    localparam int FW = $clog2(DEPTH + 1);

    slot_t [DEPTH-1:0] slot_q, slot_d;
    logic [CW-1:0]     stall_count_q, stall_count_d;
    logic              hazard_rs, hazard_rt;
    logic              alloc;

    hazard_match #(
        .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .FWD_MODE(FWD_MODE), .FW(FW)
    ) u_match_rs (
        .slots_i(slot_q), .src_i(REG_AW'(id_rs)), .used_i(id_rs_used),
        .id_valid_i(id_valid), .hazard_o(hazard_rs), .fwd_o(fwd_rs)
    );

    hazard_match #(
        .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .FWD_MODE(FWD_MODE), .FW(FW)
    ) u_match_rt (
        .slots_i(slot_q), .src_i(REG_AW'(id_rt)), .used_i(id_rt_used),
        .id_valid_i(id_valid), .hazard_o(hazard_rt), .fwd_o(fwd_rt)
    );

    // A squashed instruction never stalls, so flush masks the hazard.
    assign stall = (hazard_rs | hazard_rt) & ~flush;
    assign alloc = id_valid && id_wr_en && (id_rd != '0) && !stall && !flush;

    // The pipe shifts every cycle, even when stalled, so stalls self-clear.
    always_comb begin
        slot_d = slot_q;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            slot_d[k] = slot_q[k-1];
        end
        slot_d[0] = '0;
        if (alloc) begin
            slot_d[0].valid   = 1'b1;
            slot_d[0].rd      = REG_AW'(id_rd);
            slot_d[0].is_load = id_is_load;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CW'(1);
        end
    end

    always_comb begin
        busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_q[k].valid) begin
                busy[slot_q[k].rd] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    assign stall_count = stall_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q        <= '0;
            stall_count_q <= '0;
        end else begin
            slot_q        <= slot_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Directed bench for the hazard scoreboard: one forwarding instance and one
// stall-only instance (narrow counter to reach saturation) share the stimulus.
module tb_mips_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, flush;
    logic [4:0]  id_rs, id_rt, id_rd;

    logic        stall1, stall0;
    logic [1:0]  fwd_rs1, fwd_rt1, fwd_rs0, fwd_rt0;
    logic [31:0] busy1, busy0;
    logic [15:0] count1;
    logic [1:0]  count0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_hazard_scoreboard #(.FWD_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush), .stall(stall1),
        .fwd_rs(fwd_rs1), .fwd_rt(fwd_rt1), .busy(busy1), .stall_count(count1)
    );

    mips_hazard_scoreboard #(.FWD_MODE(0), .CW(2)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush), .stall(stall0),
        .fwd_rs(fwd_rs0), .fwd_rt(fwd_rt0), .busy(busy0), .stall_count(count0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic rsu, input logic rtu, input logic wr,
                          input logic [4:0] rd, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_wr_en = wr; id_rd = rd; id_is_load = ld;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        flush = 1'b0;
        idle();
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_stall", stall1, 0);
        chk("rst_fwd_rs", fwd_rs1, 0);
        chk("rst_fwd_rt", fwd_rt1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_count", count1, 0);
        chk("rst_busy0", busy0, 0);
        tick();

        // 1: add r3,r1,r2 ; add r4,r3,r1 ; consumer of r3 and r4
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        @(negedge clk); chk("t1_stall_a", stall1, 0);
        tick();
        set_id(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0);
        @(negedge clk);
        chk("t1_stall_b", stall1, 0);
        chk("t1_fwd_rs_b", fwd_rs1, 1);
        chk("t1_fwd_rt_b", fwd_rt1, 0);
        chk("t1_busy_b", busy1, 32'h1 << 3);
        tick();
        set_id(1, 5'd3, 5'd4, 1, 1, 1, 5'd5, 0);
        @(negedge clk);
        chk("t1_fwd_rs_c", fwd_rs1, 2);
        chk("t1_fwd_rt_c", fwd_rt1, 1);
        tick();
        idle(); tick(); tick(); tick();

        // 2: lw r5,0(r0) ; add r6,r5,r5
        do_reset();
        set_id(1, 5'd0, 5'd5, 1, 0, 1, 5'd5, 1);
        @(negedge clk); chk("t2_stall_lw", stall1, 0);
        tick();
        set_id(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0);
        @(negedge clk);
        chk("t2_stall_use", stall1, 1);
        chk("t2_fwd_rs_use", fwd_rs1, 0);
        tick();
        @(negedge clk);
        chk("t2_stall_after", stall1, 0);
        chk("t2_fwd_rs", fwd_rs1, 2);
        chk("t2_fwd_rt", fwd_rt1, 2);
        chk("t2_bubble", busy1, 32'h1 << 5);
        tick();
        idle();
        @(negedge clk);
        chk("t2_busy_issued", busy1, (32'h1 << 5) | (32'h1 << 6));
        chk("t2_count", count1, 1);
        tick(); tick(); tick();

        // 3: stall-only instance, add r3 ; add r4,r3,r1 stalls DEPTH cycles
        do_reset();
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        @(negedge clk); chk("t3_stall_a", stall0, 0);
        tick();
        set_id(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk($sformatf("t3_stall_%0d", i), stall0, 1);
            tick();
        end
        @(negedge clk);
        chk("t3_stall_clear", stall0, 0);
        chk("t3_fwd_rs", fwd_rs0, 0);
        chk("t3_fwd_rt", fwd_rt0, 0);
        tick();
        idle();
        @(negedge clk);
        chk("t3_busy", busy0, 32'h1 << 4);
        chk("t3_count", count0, 3);
        set_id(1, 5'd4, 5'd4, 1, 1, 1, 5'd7, 0);
        @(negedge clk); chk("t3_stall_more", stall0, 1);
        tick();
        idle();
        @(negedge clk); chk("t3_count_sat", count0, 3);
        tick(); tick(); tick();

        // 4: addi r4 ; add r4 ; add r0,r4,r4 ; reader of r0
        do_reset();
        set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd4, 0);
        tick();
        set_id(1, 5'd2, 5'd3, 1, 1, 1, 5'd4, 0);
        @(negedge clk);
        chk("t4_fwd_rs_nodep", fwd_rs1, 0);
        chk("t4_stall_nodep", stall1, 0);
        tick();
        set_id(1, 5'd4, 5'd4, 1, 1, 1, 5'd0, 0);
        @(negedge clk);
        chk("t4_fwd_rs_young", fwd_rs1, 1);
        chk("t4_fwd_rt_young", fwd_rt1, 1);
        chk("t4_stall_young", stall1, 0);
        chk("t4_busy_r4", busy1, 32'h1 << 4);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 1, 5'd8, 0);
        @(negedge clk);
        chk("t4_stall_r0", stall1, 0);
        chk("t4_fwd_rs_r0", fwd_rs1, 0);
        chk("t4_busy_no_r0", busy1, 32'h1 << 4);
        tick();
        idle();
        @(negedge clk); chk("t4_busy_mix", busy1, (32'h1 << 4) | (32'h1 << 8));
        tick();
        @(negedge clk); chk("t4_busy_retired", busy1, 32'h1 << 8);
        tick(); tick();

        // 5: load-use hazard coinciding with flush
        do_reset();
        set_id(1, 5'd0, 5'd5, 1, 0, 1, 5'd5, 1);
        tick();
        set_id(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0);
        flush = 1'b1;
        @(negedge clk); chk("t5_stall_flush", stall1, 0);
        tick();
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("t5_bubble", busy1, 32'h1 << 5);
        chk("t5_count", count1, 0);
        tick(); tick(); tick();

        // 6: asynchronous reset with two tags in flight
        do_reset();
        set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd2, 0);
        tick();
        set_id(1, 5'd0, 5'd3, 1, 0, 1, 5'd3, 1);
        tick();
        set_id(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0);
        @(negedge clk);
        chk("t6_busy_pre", busy1, (32'h1 << 2) | (32'h1 << 3));
        chk("t6_stall_pre", stall1, 1);
        #1 rst = 1'b0;
        #1;
        chk("t6_busy_rst", busy1, 0);
        chk("t6_stall_rst", stall1, 0);
        chk("t6_fwd_rs_rst", fwd_rs1, 0);
        chk("t6_busy0_rst", busy0, 0);
        chk("t6_stall0_rst", stall0, 0);
        #1 rst = 1'b1;
        #1;
        chk("t6_stall_rel", stall1, 0);
        @(negedge clk);
        chk("t6_busy_issued", busy1, 32'h1 << 4);
        chk("t6_count", count1, 0);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
